// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage. Owns the fetch PC and issues word reads to a
// synchronous instruction memory with a fixed 1-cycle read latency. Returned
// words are queued with their PCs in a small circular buffer. They are handed
// to decode through a valid/ready handshake. A redirect flushes the buffer and
// restarts fetch at a new address.
//
// Parameters
//   RESET_PC  word-aligned fetch address loaded on reset
//   DEPTH     instruction buffer entries (2..16); DEPTH>=3 sustains 1 instr/cycle
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous reset, active-high
//   imem_req        read request this cycle
//   imem_addr       word-aligned read address (0 when imem_req=0)
//   imem_rdata      read data, valid exactly 1 cycle after the request cycle
//   instr_valid     buffer head holds an instruction
//   instr           head instruction word (0 when instr_valid=0)
//   instr_pc        PC of the head instruction (0 when instr_valid=0)
//   instr_ready     decode accepts the head this cycle
//   redirect_valid  flush the buffer and restart fetch at redirect_pc
//   redirect_pc     new fetch address; bits [1:0] are ignored
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc;
    logic [31:0]      inflight_pc;
    logic             inflight;
    logic [31:0]      buf_instr [DEPTH];
    logic [31:0]      buf_pc    [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   credits_used;
    logic             issue;
    logic             push;
    logic             pop;

    // Pointers wrap explicitly so that DEPTH does not have to be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit-based issue. A slot is reserved for every outstanding read, so a
    // returning word always finds room. Only registered state feeds this
    // decision, which keeps instr_ready off the imem_req path.
    assign credits_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign issue        = !rst && !redirect_valid && (credits_used < DEPTH_C);
    assign imem_req     = issue;
    assign imem_addr    = issue ? fetch_pc : '0;

    // A redirect never issues in its own cycle, so after a redirect edge no
    // read is outstanding. The one word that may land in the redirect cycle
    // is discarded because the flush takes priority over the push.
    assign push = inflight;
    assign pop  = instr_valid && instr_ready;

    // The head is presented directly from the buffer and zeroed while empty.
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? buf_instr[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? buf_pc[rd_ptr]    : '0;

    // Fetch PC, in-flight tracking and buffer bookkeeping. Reset beats
    // redirect, and redirect beats normal fetch/push/pop. A pop in a redirect
    // cycle was already seen by decode, so the whole buffer is emptied.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Buffer storage. It needs no reset because entries are only read while
    // count says they are occupied.
    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid && push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]    <= inflight_pc;
        end
    end

endmodule
